// File: rtl/tape_recorder.sv
// Save-side tape recorder: run-length encodes MIC pulse widths as CSW v1 bytes and
// writes them to the SDRAM tape area through a req/ack byte port.
module tape_recorder #(
  parameter int ADDR_W = 22,
  parameter int QDEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              rec_en,
  input  logic              mic_in,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_dout,
  output logic              buf_wr,
  input  logic              buf_ack,
  output logic [ADDR_W-1:0] rec_size,
  output logic              active,
  output logic              full,
  output logic              overflow
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0]       QFULL = (PW+1)'(QDEPTH);
  localparam logic [ADDR_W+1:0] CAP   = {2'b01, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {C_IDLE, C_ARM, C_RUN, C_FLUSH} cap_e;
  typedef enum logic [1:0] {E_IDLE, E_REQ, E_GAP} enc_e;

  cap_e         cap_q;
  enc_e         enc_q;
  logic         lvl_q;
  logic [31:0]  cnt_q;
  logic [31:0]  q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]  q_cnt_q;
  logic [39:0]  sh_q;
  logic [2:0]   left_q;
  logic [ADDR_W:0] size_q;
  logic         wr_q, active_q, full_q, ovf_q;

  logic         push_req, push_ok, pop, flush, ovf_d, enc_take;
  logic [31:0]  head;
  logic         head_long;
  logic [2:0]   rec_len;
  logic [ADDR_W+1:0] need;

  always_comb begin
    head      = q_mem[rd_ptr_q];
    head_long = (head[31:8] != '0);
    rec_len   = head_long ? 3'd5 : 3'd1;
    need      = {1'b0, size_q} + {{(ADDR_W-1){1'b0}}, rec_len};
    enc_take  = (enc_q == E_IDLE) && (q_cnt_q != '0) && !full_q;
    pop       = enc_take && (need <= CAP);
    flush     = enc_take && (need > CAP);
    // A rec_en fall pushes the pulse in progress; an edge on that same ce adds nothing more.
    push_req  = ce && (cap_q == C_RUN) && !full_q && (!rec_en || (mic_in != lvl_q));
    push_ok   = push_req && !flush && ((q_cnt_q != QFULL) || pop);
    ovf_d     = push_req && !flush && (q_cnt_q == QFULL) && !pop;
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) q_mem[wr_ptr_q] <= cnt_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cap_q    <= C_IDLE;
      enc_q    <= E_IDLE;
      lvl_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_cnt_q  <= '0;
      sh_q     <= '0;
      left_q   <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      active_q <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (flush) begin
        full_q   <= 1'b1;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        q_cnt_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push_ok && !pop)      q_cnt_q <= q_cnt_q + (PW+1)'(1);
        else if (pop && !push_ok) q_cnt_q <= q_cnt_q - (PW+1)'(1);
      end
      if (ovf_d) ovf_q <= 1'b1;

      // Encoder: the cycle after an ack keeps buf_wr low and commits the byte.
      case (enc_q)
        E_IDLE: if (pop) begin
          sh_q   <= head_long ? {head, 8'h00} : {32'h0, head[7:0]};
          left_q <= rec_len - 3'd1;
          wr_q   <= 1'b1;
          enc_q  <= E_REQ;
        end
        E_REQ: if (buf_ack) begin
          wr_q  <= 1'b0;
          enc_q <= E_GAP;
        end
        E_GAP: begin
          size_q <= size_q + (ADDR_W+1)'(1);
          if (left_q != '0) begin
            left_q <= left_q - 3'd1;
            sh_q   <= {8'h00, sh_q[39:8]};
            wr_q   <= 1'b1;
            enc_q  <= E_REQ;
          end else begin
            enc_q  <= E_IDLE;
          end
        end
        default: enc_q <= E_IDLE;
      endcase

      if (ce) begin
        case (cap_q)
          C_IDLE: if (rec_en) begin
            lvl_q    <= mic_in;
            size_q   <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            active_q <= 1'b1;
            cap_q    <= C_ARM;
          end
          C_ARM: begin
            if (!rec_en) begin
              active_q <= 1'b0;
              cap_q    <= C_IDLE;
            end else if (mic_in != lvl_q) begin
              lvl_q <= mic_in;
              cnt_q <= 32'd1;
              cap_q <= C_RUN;
            end
          end
          C_RUN: begin
            if (!rec_en) begin
              cap_q <= C_FLUSH;
            end else if (mic_in != lvl_q) begin
              lvl_q <= mic_in;
              cnt_q <= 32'd1;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          C_FLUSH: if ((q_cnt_q == '0) && (enc_q == E_IDLE)) begin
            active_q <= 1'b0;
            cap_q    <= C_IDLE;
          end
          default: cap_q <= C_IDLE;
        endcase
      end
    end
  end

  // A full buffer reads back as all-ones rather than wrapping to zero.
  logic [ADDR_W-1:0] size_sat;
  assign size_sat = size_q[ADDR_W] ? '1 : size_q[ADDR_W-1:0];

  assign buf_addr = size_sat;
  assign rec_size = size_sat;
  assign buf_dout = sh_q[7:0];
  assign buf_wr   = wr_q;
  assign active   = active_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tape_recorder.sv
// Directed bench for tape_recorder: records MIC patterns and compares the written bytes.
module tb_tape_recorder;

  localparam int AW = 3;
  localparam int QD = 4;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          ce      = 1'b0;
  logic          rec_en  = 1'b0;
  logic          mic_in  = 1'b0;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_dout;
  logic          buf_wr;
  logic          buf_ack = 1'b0;
  logic [AW-1:0] rec_size;
  logic          active, full, overflow;

  tape_recorder #(.ADDR_W(AW), .QDEPTH(QD)) u_dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce       (ce),
    .rec_en   (rec_en),
    .mic_in   (mic_in),
    .buf_addr (buf_addr),
    .buf_dout (buf_dout),
    .buf_wr   (buf_wr),
    .buf_ack  (buf_ack),
    .rec_size (rec_size),
    .active   (active),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          ack_dly = 0;
  logic        ack_off = 1'b0;
  logic [7:0]  got_data [$];
  logic [AW-1:0] got_addr [$];
  logic [7:0]  exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arbiter model: acknowledges each request after ack_dly cycles and logs the byte.
  initial forever begin
    @(posedge clk_sys); #1;
    if (buf_wr && !ack_off && !reset) begin
      repeat (ack_dly) @(posedge clk_sys);
      #1;
      if (buf_wr && !reset) begin
        buf_ack = 1'b1;
        got_addr.push_back(buf_addr);
        got_data.push_back(buf_dout);
        @(posedge clk_sys); #1;
        buf_ack = 1'b0;
      end
    end
  end

  task automatic tick(input logic m, input logic en);
    mic_in = m;
    rec_en = en;
    ce = 1'b1;
    @(posedge clk_sys); #1;
    ce = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic ticks(input logic m, input int n);
    for (int i = 0; i < n; i++) tick(m, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce = 1'b0;
    rec_en = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    got_data.delete();
    got_addr.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (active && n < 2000) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check({tag, "_active_falls"}, {31'b0, active}, 32'd0);
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_nbytes"}, got_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s_byte%0d", tag, i), {24'b0, got_data[i]}, {24'b0, exp_q[i]});
        check($sformatf("%s_addr%0d", tag, i), {{(32-AW){1'b0}}, got_addr[i]}, i);
      end
    end
  endtask

  initial begin
    do_reset();
    check("rst_buf_wr",   {31'b0, buf_wr},   32'd0);
    check("rst_active",   {31'b0, active},   32'd0);
    check("rst_full",     {31'b0, full},     32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_rec_size", {29'b0, rec_size}, 32'd0);
    check("rst_buf_addr", {29'b0, buf_addr}, 32'd0);
    check("rst_buf_dout", {24'b0, buf_dout}, 32'd0);

    // T1: leading silence is not recorded
    ticks(1'b0, 100);
    check("t1_active",   {31'b0, active},   32'd1);
    check("t1_rec_size", {29'b0, rec_size}, 32'd0);
    check("t1_nbytes",   got_data.size(),   32'd0);
    tick(1'b1, 1'b1);
    ticks(1'b1, 5);
    check("t1_edge_nbytes", got_data.size(), 32'd0);
    check("t1_edge_wr",     {31'b0, buf_wr}, 32'd0);
    do_reset();

    // T2: short pulses 10/200/5
    tick(1'b1, 1'b1);
    ticks(1'b0, 10);
    ticks(1'b1, 200);
    ticks(1'b0, 5);
    check("t2_active_run", {31'b0, active}, 32'd1);
    tick(1'b0, 1'b0);
    wait_idle("t2");
    exp_q = '{8'h0A, 8'hC8, 8'h05};
    check_bytes("t2");
    check("t2_rec_size", {29'b0, rec_size}, 32'd3);
    check("t2_overflow", {31'b0, overflow}, 32'd0);
    do_reset();

    // T3: long (300) and boundary (255) pulses, then a 1-ce tail
    tick(1'b1, 1'b1);
    ticks(1'b0, 300);
    ticks(1'b1, 255);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    wait_idle("t3");
    exp_q = '{8'h00, 8'h2C, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h01};
    check_bytes("t3");
    check("t3_rec_size", {29'b0, rec_size}, 32'd7);
    check("t3_full",     {31'b0, full},     32'd0);
    do_reset();

    // T4: slow ack, 1-ce pulses overflow the queue
    ack_dly = 50;
    tick(1'b1, 1'b1);
    for (int i = 0; i <= 8; i++) tick((i % 2) != 0, 1'b1);
    tick(1'b0, 1'b0);
    check("t4_overflow_early", {31'b0, overflow}, 32'd1);
    wait_idle("t4");
    exp_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    check_bytes("t4");
    check("t4_rec_size", {29'b0, rec_size}, 32'd5);
    check("t4_overflow", {31'b0, overflow}, 32'd1);
    ack_dly = 0;
    do_reset();

    // T5: six 1-byte records fill 6 of 8; a 5-byte record does not fit
    tick(1'b1, 1'b1);
    ticks(1'b0, 2);
    ticks(1'b1, 3);
    ticks(1'b0, 4);
    ticks(1'b1, 5);
    ticks(1'b0, 6);
    ticks(1'b1, 7);
    ticks(1'b0, 300);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    wait_idle("t5");
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    check_bytes("t5");
    check("t5_rec_size", {29'b0, rec_size}, 32'd6);
    check("t5_full",     {31'b0, full},     32'd1);
    check("t5_overflow", {31'b0, overflow}, 32'd0);
    do_reset();

    // T6: reset while a request is pending
    ack_off = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 20 && !buf_wr; i++) begin
      @(posedge clk_sys); #1;
    end
    check("t6_wr_pending", {31'b0, buf_wr}, 32'd1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("t6_wr_dropped", {31'b0, buf_wr},   32'd0);
    check("t6_active",     {31'b0, active},   32'd0);
    check("t6_rec_size",   {29'b0, rec_size}, 32'd0);
    check("t6_buf_addr",   {29'b0, buf_addr}, 32'd0);
    check("t6_buf_dout",   {24'b0, buf_dout}, 32'd0);
    reset = 1'b0;
    ack_off = 1'b0;
    tick(1'b0, 1'b0);
    ticks(1'b0, 3);
    tick(1'b0, 1'b0);
    check("t6_idle_after", {31'b0, active},  32'd0);
    check("t6_no_commit",  got_data.size(),  32'd0);
    check("t6_wr_quiet",   {31'b0, buf_wr},  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
